// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC source encoding for the PC sequencer.
package pc_pkg;

   localparam int          DEFAULT_XLEN         = 32;
   localparam int          DEFAULT_STEP         = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BR,
      SEL_JMP,
      SEL_RET
   } next_pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry,
// and the top entry is readable combinationally so a return can redirect in the same cycle.
module pc_ras #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] r_mem [DEPTH];
   logic [PW-1:0]   r_ptr;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   w_ptr_inc;
   logic            w_do_pop;
   logic            w_do_push;

   assign w_ptr_inc = r_ptr + PW'(1);
   assign w_do_pop  = pop && (r_count != '0);
   // A pop that coincides with a push takes precedence; the sequencer never requests both.
   assign w_do_push = push && !w_do_pop;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (w_do_pop) begin
         r_ptr   <= r_ptr - PW'(1);
         r_count <= r_count - CW'(1);
      end else if (w_do_push) begin
         r_ptr <= w_ptr_inc;
         if (r_count != CW'(DEPTH)) begin
            r_count <= r_count + CW'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset_n && w_do_push) begin
         r_mem[w_ptr_inc] <= wdata;
      end
   end

   assign top   = r_mem[r_ptr];
   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// PC register with prioritised next-PC selection (hold, return, jump, branch, sequential)
// and a return-address stack for call/return.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = DEFAULT_XLEN,
   parameter int              STEP         = DEFAULT_STEP,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter int              BRANCH_SHIFT = 2,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            Stall,
   input  logic            BranchTaken,
   input  logic [XLEN-1:0] BranchOffset,
   input  logic            JumpValid,
   input  logic [XLEN-1:0] JumpTarget,
   input  logic            Call,
   input  logic            Ret,
   output logic [XLEN-1:0] PCResult,
   output logic [XLEN-1:0] PCAddResult,
   output logic            RasEmpty,
   output logic            RasFull,
   output logic            RasErr
);

   logic [XLEN-1:0] r_pc;
   logic            r_ras_err;
   logic [XLEN-1:0] w_pc_add;
   logic [XLEN-1:0] w_branch_target;
   logic [XLEN-1:0] w_next_pc;
   logic [XLEN-1:0] w_ras_top;
   logic            w_ras_empty;
   logic            w_ras_full;
   logic            w_push;
   logic            w_pop;
   logic            w_ret_empty;
   next_pc_sel_t    w_sel;

   assign w_pc_add        = r_pc + XLEN'(STEP);
   assign w_branch_target = w_pc_add + (BranchOffset << BRANCH_SHIFT);

   always_comb begin
      w_sel = SEL_SEQ;
      if (Stall) begin
         w_sel = SEL_HOLD;
      end else if (Ret) begin
         w_sel = SEL_RET;
      end else if (JumpValid) begin
         w_sel = SEL_JMP;
      end else if (BranchTaken) begin
         w_sel = SEL_BR;
      end
   end

   // A return with nothing on the stack falls through to the sequential address.
   always_comb begin
      w_next_pc = w_pc_add;
      case (w_sel)
         SEL_HOLD: w_next_pc = r_pc;
         SEL_RET:  w_next_pc = w_ras_empty ? w_pc_add : w_ras_top;
         SEL_JMP:  w_next_pc = JumpTarget;
         SEL_BR:   w_next_pc = w_branch_target;
         default:  w_next_pc = w_pc_add;
      endcase
   end

   assign w_push      = (w_sel == SEL_JMP) && Call;
   assign w_pop       = (w_sel == SEL_RET) && !w_ras_empty;
   assign w_ret_empty = (w_sel == SEL_RET) && w_ras_empty;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_pc      <= RESET_VECTOR;
         r_ras_err <= 1'b0;
      end else begin
         r_pc      <= w_next_pc;
         r_ras_err <= w_ret_empty;
      end
   end

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .XLEN  (XLEN)
   ) u_ras (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .wdata   (w_pc_add),
      .top     (w_ras_top),
      .empty   (w_ras_empty),
      .full    (w_ras_full)
   );

   assign PCResult    = r_pc;
   assign PCAddResult = w_pc_add;
   assign RasEmpty    = w_ras_empty;
   assign RasFull     = w_ras_full;
   assign RasErr      = r_ras_err;

endmodule
